alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 r0_valid, r1_valid  input  1 each  requester n has an operation pending.
REQ-005 r0_ready, r1_ready  output  1 each  requester n accepted this cycle (valid & ready = transfer).
REQ-006 r0_a, r0_b, r1_a, r1_b  input  WIDTH each  operands of requester n.
REQ-007 r0_op, r1_op  input  3 each  ALU control code of requester n.
REQ-008 alu_a, alu_b  output  WIDTH each  operands driven to the shared ALU.
REQ-009 alu_ctrl  output  3  control code driven to the shared ALU.
REQ-010 alu_result  input  WIDTH  combinational result returned by the shared ALU.
REQ-011 r0_rvalid, r1_rvalid  output  1 each  response register of requester n holds a result.
REQ-012 r0_rready, r1_rready  input  1 each  requester n consumes its response this cycle.
REQ-013 r0_result, r1_result  output  WIDTH each  registered result for requester n.

Function
REQ-014 Port n is eligible when rn_valid=1 and (rn_rvalid=0 or rn_rready=1).
REQ-015 At most one port granted per cycle; grant is combinational from eligibility and the round-robin pointer.
REQ-016 Only one port eligible: that port is granted regardless of pointer.
REQ-017 Both eligible: port indicated by pointer (0 or 1) is granted.
REQ-018 Pointer updates on every grant to the non-granted port index; unchanged in cycles with no grant.
REQ-019 rn_ready = 1 exactly in cycles port n is granted.
REQ-020 alu_a/alu_b/alu_ctrl carry the granted port's operands/code; with no grant they carry port 0 inputs with alu_ctrl forced to 3'b000.
REQ-021 op codes forwarded unmodified, including unsupported codes 011/111 (ALU returns 0).
REQ-022 On grant of port n, alu_result is captured into rn_result at the same edge and rn_rvalid is set: latency exactly 1 cycle from accept to rn_rvalid.
REQ-023 rn_rvalid clears at the edge where rn_rready=1 and no new grant to port n occurs in that cycle.
REQ-024 Simultaneous rn_rready=1 and new grant to port n: rn_result overwritten with new value, rn_rvalid stays 1 (back-to-back throughput of one op per cycle per port).
REQ-025 rn_result and rn_rvalid held stable while rn_rvalid=1 and rn_rready=0.
REQ-026 Non-granted port's response registers unaffected by the other port's grant.
REQ-027 rn_rready while rn_rvalid=0 has no effect.
REQ-028 Result width: WIDTH bits, no extension or truncation by this block.

Reset
REQ-029 While reset=1 at an edge: r0_rvalid=r1_rvalid=0, r0_result=r1_result=0, pointer=0.
REQ-030 While reset=1, r0_ready=r1_ready=0 and no capture occurs; in-flight responses discarded.
REQ-031 First cycle after reset deasserts: normal arbitration, port 0 priority on contention.

Verification
REQ-032 Single op: reset, r0_valid=1, a=5, b=3, op=010 -> r0_ready=1 that cycle; next cycle r0_rvalid=1, r0_result=8.
REQ-033 Contention: after reset both valid (r0 op=000 a=0xF0 b=0x3C; r1 op=100 a=10 b=4) with rready=1 -> cycle 1 grants r0 (result 0x30), cycle 2 grants r1 (result 6), then alternates.
REQ-034 Backpressure: r0_rvalid=1, r0_rready=0, r0_valid=1 -> r0_ready=0, r0_result held; r1 requests still granted every cycle.
REQ-035 Back-to-back: r0_valid=1 and r0_rready=1 continuously, op=010 a=i b=1 -> one result per cycle, results i+1 in order, r0_rvalid never drops.
REQ-036 Reset mid-operation: r1_rvalid=1 with result 0x1234, reset pulse one cycle -> r1_rvalid=0, r1_result=0, pointer=0 next cycle.
REQ-037 Unsupported code: r1 op=111 a=7 b=7 -> r1_result=0 one cycle later, alu_ctrl observed as 111 during grant.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// Each requester has a one-entry response register with valid/ready handshake.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  input  logic             r1_valid,
  output logic             r0_ready,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [2:0]       r0_op,
  input  logic [2:0]       r1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             r0_rvalid,
  output logic             r1_rvalid,
  input  logic             r0_rready,
  input  logic             r1_rready,
  output logic [WIDTH-1:0] r0_result,
  output logic [WIDTH-1:0] r1_result
);

  logic ptr;
  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

  // A port may issue only if its response slot is free or being drained now.
  always_comb begin
    elig0  = r0_valid && (!r0_rvalid || r0_rready) && !reset;
    elig1  = r1_valid && (!r1_rvalid || r1_rready) && !reset;
    grant0 = elig0 && (!elig1 || !ptr);
    grant1 = elig1 && (!elig0 || ptr);
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  // Steer the granted port to the ALU; idle cycles show port 0 with a neutral code.
  always_comb begin
    if (grant1) begin
      alu_a    = r1_a;
      alu_b    = r1_b;
      alu_ctrl = r1_op;
    end else if (grant0) begin
      alu_a    = r0_a;
      alu_b    = r0_b;
      alu_ctrl = r0_op;
    end else begin
      alu_a    = r0_a;
      alu_b    = r0_b;
      alu_ctrl = 3'b000;
    end
  end

  // Pointer moves to the loser on every grant so contention alternates.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (grant0) begin
      ptr <= 1'b1;
    end else if (grant1) begin
      ptr <= 1'b0;
    end else begin
      ptr <= ptr;
    end
  end

  // Port 0 response slot: a new grant overwrites even while the old result drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      r0_rvalid <= 1'b0;
      r0_result <= {WIDTH{1'b0}};
    end else if (grant0) begin
      r0_rvalid <= 1'b1;
      r0_result <= alu_result;
    end else if (r0_rready) begin
      r0_rvalid <= 1'b0;
      r0_result <= r0_result;
    end else begin
      r0_rvalid <= r0_rvalid;
      r0_result <= r0_result;
    end
  end

  // Port 1 response slot, same behaviour as port 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_rvalid <= 1'b0;
      r1_result <= {WIDTH{1'b0}};
    end else if (grant1) begin
      r1_rvalid <= 1'b1;
      r1_result <= alu_result;
    end else if (r1_rready) begin
      r1_rvalid <= 1'b0;
      r1_result <= r1_result;
    end else begin
      r1_rvalid <= r1_rvalid;
      r1_result <= r1_result;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Table-driven bench for alu_share_arbiter with per-port result scoreboards
// and a hand-written reset-during-response sequence.
module tb_alu_share_arbiter;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             r0_valid, r1_valid, r0_ready, r1_ready;
  logic [WIDTH-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0]       r0_op, r1_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_ctrl;
  logic             r0_rvalid, r1_rvalid, r0_rready, r1_rready;
  logic [WIDTH-1:0] r0_result, r1_result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r1_valid(r1_valid),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
    .r0_op(r0_op), .r1_op(r1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result),
    .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rready(r0_rready), .r1_rready(r1_rready),
    .r0_result(r0_result), .r1_result(r1_result)
  );

  // Shared ALU: 000 and, 001 or, 010 add, 100 sub, 101 xor, 110 nor, 011/111 zero.
  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a - b;
      3'b101:  return a ^ b;
      3'b110:  return ~(a | b);
      default: return {WIDTH{1'b0}};
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);

  typedef struct {
    logic             rst, v0, v1, rr0, rr1;
    logic [2:0]       op0, op1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             g0, g1;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic v0, input logic v1,
                              input logic rr0, input logic rr1,
                              input logic [2:0] op0, input logic [WIDTH-1:0] a0,
                              input logic [WIDTH-1:0] b0,
                              input logic [2:0] op1, input logic [WIDTH-1:0] a1,
                              input logic [WIDTH-1:0] b1,
                              input logic g0, input logic g1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1; v.rr0 = rr0; v.rr1 = rr1;
    v.op0 = op0; v.a0 = a0; v.b0 = b0; v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; r0_valid = v.v0; r1_valid = v.v1;
    r0_rready = v.rr0; r1_rready = v.rr1;
    r0_op = v.op0; r0_a = v.a0; r0_b = v.b0;
    r1_op = v.op1; r1_a = v.a1; r1_b = v.b1;
  endtask

  vec_t             vecs [20];
  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];
  vec_t             h;

  initial begin
    // rows: rst v0 v1 rr0 rr1 | op0 a0 b0 | op1 a1 b1 | expected g0 g1
    vecs[0]  = mk(1, 1, 1, 1, 1, 3'b010, 5, 3, 3'b100, 10, 4, 0, 0);
    vecs[1]  = mk(0, 1, 0, 1, 1, 3'b010, 5, 3, 3'b100, 10, 4, 1, 0);
    vecs[2]  = mk(0, 0, 0, 1, 1, 3'b010, 5, 3, 3'b100, 10, 4, 0, 0);
    vecs[3]  = mk(0, 0, 1, 1, 1, 3'b001, 2, 2, 3'b111, 7, 7, 0, 1);
    vecs[4]  = mk(0, 0, 0, 1, 0, 3'b001, 2, 2, 3'b111, 7, 7, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 0, 3'b001, 2, 2, 3'b111, 7, 7, 0, 0);
    vecs[6]  = mk(1, 1, 1, 1, 1, 3'b000, 32'hF0, 32'h3C, 3'b100, 10, 4, 0, 0);
    vecs[7]  = mk(0, 1, 1, 1, 1, 3'b000, 32'hF0, 32'h3C, 3'b100, 10, 4, 1, 0);
    vecs[8]  = mk(0, 1, 1, 1, 1, 3'b000, 32'hF0, 32'h3C, 3'b100, 10, 4, 0, 1);
    vecs[9]  = mk(0, 1, 1, 1, 1, 3'b000, 32'hF0, 32'h3C, 3'b100, 10, 4, 1, 0);
    vecs[10] = mk(0, 1, 1, 1, 1, 3'b000, 32'hF0, 32'h3C, 3'b100, 10, 4, 0, 1);
    vecs[11] = mk(0, 1, 1, 0, 1, 3'b101, 32'hFF, 32'h0F, 3'b100, 20, 5, 1, 0);
    vecs[12] = mk(0, 1, 1, 0, 1, 3'b110, 32'h1, 32'h2, 3'b100, 30, 6, 0, 1);
    vecs[13] = mk(0, 1, 1, 0, 1, 3'b110, 32'h1, 32'h2, 3'b010, 40, 7, 0, 1);
    vecs[14] = mk(0, 1, 1, 1, 1, 3'b010, 99, 1, 3'b010, 50, 8, 1, 0);
    vecs[15] = mk(0, 1, 0, 1, 1, 3'b010, 100, 1, 3'b000, 0, 0, 1, 0);
    vecs[16] = mk(0, 1, 0, 1, 1, 3'b010, 101, 1, 3'b000, 0, 0, 1, 0);
    vecs[17] = mk(0, 1, 0, 1, 1, 3'b011, 9, 9, 3'b000, 0, 0, 1, 0);
    vecs[18] = mk(0, 0, 0, 1, 1, 3'b000, 1, 1, 3'b000, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 1, 1, 3'b000, 1, 1, 3'b000, 0, 0, 0, 0);

    drive(vecs[0]);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      #4;
      chk("r0_ready", r0_ready, vecs[i].g0);
      chk("r1_ready", r1_ready, vecs[i].g1);
      chk("alu_ctrl", alu_ctrl, vecs[i].g1 ? vecs[i].op1 : (vecs[i].g0 ? vecs[i].op0 : 3'b000));
      chk("alu_a", alu_a, vecs[i].g1 ? vecs[i].a1 : vecs[i].a0);
      chk("alu_b", alu_b, vecs[i].g1 ? vecs[i].b1 : vecs[i].b0);
      chk("r0_rvalid", r0_rvalid, q0.size() != 0);
      chk("r1_rvalid", r1_rvalid, q1.size() != 0);
      if (r0_rvalid && q0.size() != 0) begin
        chk("r0_result", r0_result, q0[0]);
        if (vecs[i].rr0) void'(q0.pop_front());
      end
      if (r1_rvalid && q1.size() != 0) begin
        chk("r1_result", r1_result, q1[0]);
        if (vecs[i].rr1) void'(q1.pop_front());
      end
      if (vecs[i].g0) q0.push_back(alu_f(vecs[i].a0, vecs[i].b0, vecs[i].op0));
      if (vecs[i].g1) q1.push_back(alu_f(vecs[i].a1, vecs[i].b1, vecs[i].op1));
      if (vecs[i].rst) begin
        q0.delete();
        q1.delete();
      end
    end
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    // Reset while a held response is pending and the pointer favours port 1.
    h = mk(0, 0, 1, 0, 0, 3'b000, 0, 0, 3'b010, 32'h1000, 32'h0234, 0, 0);
    @(posedge clk); #1; drive(h); #4;
    chk("seq_a_r1_ready", r1_ready, 1'b1);
    h = mk(0, 1, 0, 1, 0, 3'b010, 1, 1, 3'b000, 0, 0, 0, 0);
    @(posedge clk); #1; drive(h); #4;
    chk("seq_b_r0_ready", r0_ready, 1'b1);
    chk("seq_b_r1_result", r1_result, 32'h1234);
    h = mk(1, 1, 1, 0, 0, 3'b010, 1, 1, 3'b010, 2, 2, 0, 0);
    @(posedge clk); #1; drive(h); #4;
    chk("seq_c_r0_ready", r0_ready, 1'b0);
    chk("seq_c_r1_ready", r1_ready, 1'b0);
    chk("seq_c_r1_rvalid", r1_rvalid, 1'b1);
    chk("seq_c_r1_result", r1_result, 32'h1234);
    h = mk(0, 1, 1, 1, 1, 3'b010, 1, 1, 3'b010, 2, 2, 0, 0);
    @(posedge clk); #1; drive(h); #4;
    chk("seq_d_r1_rvalid", r1_rvalid, 1'b0);
    chk("seq_d_r1_result", r1_result, 32'h0);
    chk("seq_d_r0_rvalid", r0_rvalid, 1'b0);
    chk("seq_d_r0_result", r0_result, 32'h0);
    chk("seq_d_r0_ready", r0_ready, 1'b1);
    chk("seq_d_r1_ready", r1_ready, 1'b0);
    h = mk(0, 0, 0, 1, 1, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0);
    @(posedge clk); #1; drive(h); #4;
    chk("seq_e_r0_rvalid", r0_rvalid, 1'b1);
    chk("seq_e_r0_result", r0_result, 32'h2);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
